// File: rtl/multicycle_controller.sv
// Control FSM for a shared-ALU, shared-memory multicycle RV32I datapath.
// Optional build macro MC_ILLEGAL_TRAP_EN adds a sticky TRAP state and an illegal output.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
`ifdef MC_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd11
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  state_t     state_q, state_d;
  alu_op_t    alu_op;
  logic       pc_update, branch, ir_write, reg_write, mem_write, adr_src, illegal_int;
  logic [1:0] result_src, alu_src_a, alu_src_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    illegal_int = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_int = 1'b1;
        state_d     = S_TRAP;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // funct3=000 is sub only for R-type; immediates never subtract.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      ALU_SUB: ALUControl = 3'b001;
      ALU_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write enables are gated by reset so nothing commits while the FSM is held in FETCH.
  assign PCWrite   = reset & (pc_update | (branch & Zero));
  assign IRWrite   = reset & ir_write;
  assign RegWrite  = reset & reg_write;
  assign MemWrite  = reset & mem_write;
  assign AdrSrc    = adr_src;
  assign ResultSrc = result_src;
  assign ALUSrcA   = alu_src_a;
  assign ALUSrcB   = alu_src_b;
  assign state     = state_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal   = illegal_int;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction state paths expanded into expected
// control words, checked every cycle, plus directed literal checks for reset and key points.
module tb_multicycle_controller;

  localparam int W = 21;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  logic       dut_illegal;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cmp_exp, cmp_act;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite),
`ifdef MC_ILLEGAL_TRAP_EN
    .illegal(dut_illegal),
`endif
    .state(state)
  );

`ifndef MC_ILLEGAL_TRAP_EN
  assign dut_illegal = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit, got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model ----------------
  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [W-1:0] ctrl_word(input int st, input logic [6:0] o, input logic [2:0] f3,
                                             input logic f7, input logic z);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    {pcw, adr, mw, irw, rw, ill} = '0;
    {rs, sa, sb} = '0;
    alu = 3'b000;
    imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 : (o == 7'b1101111) ? 2'b11 : 2'b00;
    case (st)
      0:  begin irw = 1; sb = 2'b10; rs = 2'b10; pcw = 1; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  begin adr = 1; end
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2'b10; alu = funct_alu(o, f3, f7); end
      7:  begin rw = 1; end
      8:  begin sa = 2'b10; sb = 2'b01; alu = funct_alu(o, f3, f7); end
      9:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      10: begin sa = 2'b10; alu = 3'b001; pcw = z; end
      11: begin ill = 1; end
      default: ;
    endcase
    return {4'(st), ill, pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_exp = exp_q.pop_front();
      cmp_act = {state, dut_illegal, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
      n_vec++;
      if (cmp_act !== cmp_exp) begin
        n_err++;
        $display("FAIL cycle t=%0t op=%b got=%h want=%h (state got=%0d want=%0d)",
                 $time, op, cmp_act, cmp_exp, cmp_act[W-1 -: 4], cmp_exp[W-1 -: 4]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, want);
    end
  endtask

  task automatic set_inputs(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
  endtask

  // Drive one instruction starting in FETCH; queue its expected per-cycle control words.
  task automatic start_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, output int n);
    int path[$];
    set_inputs(o, f3, f7, z);
    case (o)
      7'b0000011: path = '{0, 1, 2, 3, 4};
      7'b0100011: path = '{0, 1, 2, 5};
      7'b0110011: path = '{0, 1, 6, 7};
      7'b0010011: path = '{0, 1, 8, 7};
      7'b1101111: path = '{0, 1, 9, 7};
      7'b1100011: path = '{0, 1, 10};
`ifdef MC_ILLEGAL_TRAP_EN
      default:    path = '{0, 1, 11, 11, 11};
`else
      default:    path = '{0, 1};
`endif
    endcase
    foreach (path[i]) exp_q.push_back(ctrl_word(path[i], o, f3, f7, z));
    n = path.size();
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    int n;
    start_instr(o, f3, f7, z, n);
    repeat (n) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b0;
    set_inputs(7'b0, 3'b0, 1'b0, 1'b0);
    #3;
    check("rst_state", 32'(state), 32'd0);
    check("rst_enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    check("rst_fetch_mux", 32'({ALUSrcA, ALUSrcB, ResultSrc, AdrSrc}), 32'({2'b00, 2'b10, 2'b10, 1'b0}));
    tick();
    check("rst_hold", 32'({state, PCWrite, IRWrite}), 32'd0);

    // Release reset; lw runs 0,1,2,3,4
    reset = 1'b1;
    start_instr(7'b0000011, 3'b010, 1'b0, 1'b0, n);
    #1;
    check("rel_irwrite", 32'(IRWrite), 32'd1);
    check("rel_pcwrite", 32'(PCWrite), 32'd1);
    repeat (n) tick();

    run_instr(7'b0100011, 3'b010, 1'b0, 1'b1);   // sw, Zero high must not matter
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b1);   // add

    start_instr(7'b0110011, 3'b000, 1'b1, 1'b0, n);  // sub
    tick(); tick();
    check("sub_alu", 32'({state, ALUControl}), 32'({4'd6, 3'b001}));
    tick(); tick();

    start_instr(7'b0010011, 3'b000, 1'b1, 1'b0, n);  // addi with funct7b5 set
    tick(); tick();
    check("addi_alu", 32'({state, ALUControl}), 32'({4'd8, 3'b000}));
    tick(); tick();

    start_instr(7'b0110011, 3'b010, 1'b0, 1'b0, n);  // slt
    tick(); tick();
    check("slt_alu", 32'({state, ALUControl}), 32'({4'd6, 3'b101}));
    tick(); tick();

    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0);   // or
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0);   // and
    run_instr(7'b0110011, 3'b001, 1'b0, 1'b0);   // unlisted funct3 -> add
    run_instr(7'b0010011, 3'b111, 1'b0, 1'b0);   // andi
    run_instr(7'b0010011, 3'b110, 1'b0, 1'b0);   // ori
    run_instr(7'b0010011, 3'b010, 1'b0, 1'b0);   // slti

    start_instr(7'b1100011, 3'b000, 1'b0, 1'b1, n);  // beq taken
    tick(); tick();
    check("beq_taken", 32'({state, PCWrite, ImmSrc}), 32'({4'd10, 1'b1, 2'b10}));
    tick();
    check("beq_taken_ret", 32'(state), 32'd0);

    start_instr(7'b1100011, 3'b000, 1'b0, 1'b0, n);  // beq not taken
    tick(); tick();
    check("beq_not_taken", 32'({state, PCWrite}), 32'({4'd10, 1'b0}));
    tick();
    check("beq_nt_ret", 32'(state), 32'd0);

    start_instr(7'b1101111, 3'b000, 1'b0, 1'b0, n);  // jal
    tick(); tick();
    check("jal_pcw", 32'({state, PCWrite, ImmSrc}), 32'({4'd9, 1'b1, 2'b11}));
    tick(); tick();

    // Reset asserted mid-lw while in MEMREAD
    set_inputs(7'b0000011, 3'b010, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("mr_in_memread", 32'({state, AdrSrc}), 32'({4'd3, 1'b1}));
    reset = 1'b0;
    #1;
    check("mr_async_state", 32'(state), 32'd0);
    check("mr_enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    tick();
    check("mr_hold", 32'({state, PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    reset = 1'b1;
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0);   // sw after recovery

    // Unsupported opcode
`ifdef MC_ILLEGAL_TRAP_EN
    start_instr(7'b1111111, 3'b000, 1'b0, 1'b0, n);
    repeat (n) tick();
    check("trap_hold", 32'({state, dut_illegal, PCWrite, IRWrite, RegWrite, MemWrite}),
          32'({4'd11, 1'b1, 4'b0000}));
    reset = 1'b0;
    #1;
    check("trap_clear", 32'({state, dut_illegal}), 32'd0);
    reset = 1'b1;
`else
    start_instr(7'b1111111, 3'b000, 1'b0, 1'b0, n);
    repeat (n) tick();
    check("illegal_ret", 32'(state), 32'd0);
`endif

    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d left want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
